// File: rtl/noc_pkg.sv
// Shared definitions for the NoC switch allocator: port numbering, widths,
// the per-output lock state and the round-robin index step.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = 3;

    // Port numbering used on every vector and index of the allocator.
    // PORT_W is taken by the index width, so west is spelled out.
    typedef enum logic [PORT_W-1:0] {
        PORT_N    = 3'd0,
        PORT_S    = 3'd1,
        PORT_E    = 3'd2,
        PORT_WEST = 3'd3,
        PORT_L    = 3'd4
    } port_e;

    // Per-output wormhole lock: idle (arbitrating) or held by one input.
    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_e;

    // Next port index, wrapping L back to N.
    function automatic logic [PORT_W-1:0] port_next(input logic [PORT_W-1:0] p);
        return (p >= 3'(PORT_L)) ? 3'(PORT_N) : (p + 3'd1);
    endfunction

endpackage

// File: rtl/noc_switch_alloc_chk.sv
// Protocol checks for the switch allocator: illegal head-flit destinations
// (out of range or U-turn) and credit returns beyond the buffer depth.
// Reported as warnings: the allocator tolerates both (never grants / saturates).
module noc_switch_alloc_chk
    import noc_pkg::*;
(
    input logic                        clk,
    input logic                        rst,
    input logic [NUM_PORTS-1:0]        req_valid_i,
    input logic [NUM_PORTS*PORT_W-1:0] req_dest_i,
    input logic [NUM_PORTS-1:0]        held_i,
    input logic [NUM_PORTS-1:0]        sat_ret_i
);

    // Sample every head flit and every credit return once per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_valid_i[i] && !held_i[i]) begin
                    assert ((req_dest_i[PORT_W*i +: PORT_W] < 3'(NUM_PORTS)) &&
                            (req_dest_i[PORT_W*i +: PORT_W] != 3'(i)))
                    else $warning("noc_switch_alloc: input %0d head has illegal destination %0d",
                                  i, req_dest_i[PORT_W*i +: PORT_W]);
                end
                assert (!sat_ret_i[i])
                else $warning("noc_switch_alloc: credit return on full output %0d", i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Five-request round-robin arbiter: picks the first asserted request
// searching ptr+1, ptr+2, ... (mod 5). Purely combinational.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    ptr_i,
    output logic                 gnt_valid_o,
    output logic [PORT_W-1:0]    gnt_idx_o
);

    logic [PORT_W-1:0] cand_s;

    // Walk the five positions after the pointer and keep the first hit.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = 3'd0;
        cand_s      = ptr_i;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_s = port_next(cand_s);
            if (!gnt_valid_o && req_i[cand_s]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand_s;
            end else begin
                gnt_valid_o = gnt_valid_o;
            end
        end
    end

endmodule

// File: rtl/noc_switch_alloc.sv
// Switch allocator for one 5-port NoC router. Per output: wormhole lock,
// round-robin pointer and downstream credit counter. Grants, crossbar
// selects and queue pops are combinational from the current heads.
module noc_switch_alloc
    import noc_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid_i,
    input  logic [NUM_PORTS*PORT_W-1:0] req_dest_i,
    input  logic [NUM_PORTS-1:0]        req_tail_i,
    input  logic [NUM_PORTS-1:0]        credit_return_i,
    output logic [NUM_PORTS-1:0]        pop_o,
    output logic [NUM_PORTS-1:0]        grant_access_o,
    output logic [NUM_PORTS*PORT_W-1:0] address_route_o
);

    localparam int CW = $clog2(CREDITS + 1);

    lock_e                             lock_q  [NUM_PORTS];
    lock_e                             lock_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0][PORT_W-1:0]  owner_q, owner_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0]  ptr_q, ptr_d;
    logic [NUM_PORTS-1:0][CW-1:0]      cred_q, cred_d;

    logic [NUM_PORTS-1:0]              held_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] cand_s;
    logic [NUM_PORTS-1:0]              arb_vld_s;
    logic [NUM_PORTS-1:0][PORT_W-1:0]  arb_idx_s;
    logic [NUM_PORTS-1:0]              gnt_s;
    logic [NUM_PORTS-1:0][PORT_W-1:0]  sel_s;
    logic [NUM_PORTS-1:0]              sat_ret_s;

    // Arbitration candidates: free inputs heading here, no U-turn, credit available.
    always_comb begin
        held_s = '0;
        cand_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (lock_q[o] == LOCK_HELD) begin
                held_s[owner_q[o]] = 1'b1;
            end else begin
                held_s = held_s;
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand_s[o][i] = req_valid_i[i] &&
                               (req_dest_i[PORT_W*i +: PORT_W] == 3'(o)) &&
                               !held_s[i] && (i != o) && (cred_q[o] != '0);
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .req_i       (cand_s[o]),
            .ptr_i       (ptr_q[o]),
            .gnt_valid_o (arb_vld_s[o]),
            .gnt_idx_o   (arb_idx_s[o])
        );
    end

    // Per-output grant: a held output follows its owner, an idle one the arbiter.
    always_comb begin
        gnt_s = '0;
        sel_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (lock_q[o] == LOCK_HELD) begin
                gnt_s[o] = req_valid_i[owner_q[o]] && (cred_q[o] != '0);
                sel_s[o] = gnt_s[o] ? owner_q[o] : 3'd0;
            end else begin
                gnt_s[o] = arb_vld_s[o];
                sel_s[o] = arb_vld_s[o] ? arb_idx_s[o] : 3'd0;
            end
        end
    end

    // Drive crossbar controls and pops; all quiet while reset is held.
    always_comb begin
        pop_o           = '0;
        grant_access_o  = '0;
        address_route_o = '0;
        if (rst) begin
            pop_o = '0;
        end else begin
            grant_access_o  = gnt_s;
            address_route_o = sel_s;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (gnt_s[o]) begin
                    pop_o[sel_s[o]] = 1'b1;
                end else begin
                    pop_o = pop_o;
                end
            end
        end
    end

    // Next lock, pointer and credit state for each output.
    always_comb begin
        lock_d    = lock_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cred_d    = cred_q;
        sat_ret_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt_s[o] && (lock_q[o] == LOCK_IDLE)) begin
                ptr_d[o] = sel_s[o];
                if (!req_tail_i[sel_s[o]]) begin
                    lock_d[o]  = LOCK_HELD;
                    owner_d[o] = sel_s[o];
                end else begin
                    lock_d[o]  = LOCK_IDLE;
                end
            end else if (gnt_s[o] && req_tail_i[sel_s[o]]) begin
                lock_d[o] = LOCK_IDLE;
            end else begin
                lock_d[o] = lock_q[o];
            end
            case ({gnt_s[o], credit_return_i[o]})
                2'b10: cred_d[o] = cred_q[o] - CW'(1);
                2'b01: begin
                    if (cred_q[o] != CW'(CREDITS)) begin
                        cred_d[o] = cred_q[o] + CW'(1);
                    end else begin
                        sat_ret_s[o] = 1'b1;
                    end
                end
                default: cred_d[o] = cred_q[o];
            endcase
        end
    end

    // State registers with synchronous reset to idle, full credit, pointer at L.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                lock_q[o]  <= LOCK_IDLE;
                owner_q[o] <= 3'd0;
                ptr_q[o]   <= 3'(PORT_L);
                cred_q[o]  <= CW'(CREDITS);
            end
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cred_q  <= cred_d;
        end
    end

    noc_switch_alloc_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_dest_i  (req_dest_i),
        .held_i      (held_s),
        .sat_ret_i   (sat_ret_s)
    );

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Scoreboard bench for noc_switch_alloc: a behavioural allocator model
// predicts pop/grant/route for every driven cycle; predictions are queued
// and compared against the DUT at the falling edge.
module tb_noc_switch_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_valid_i;
    logic [14:0] req_dest_i;
    logic [4:0]  req_tail_i;
    logic [4:0]  credit_return_i;
    logic [4:0]  pop_o;
    logic [4:0]  grant_access_o;
    logic [14:0] address_route_o;

    always #5 clk = ~clk;

    noc_switch_alloc #(.CREDITS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_dest_i      (req_dest_i),
        .req_tail_i      (req_tail_i),
        .credit_return_i (credit_return_i),
        .pop_o           (pop_o),
        .grant_access_o  (grant_access_o),
        .address_route_o (address_route_o)
    );

    typedef struct packed {
        logic [4:0]  pop;
        logic [4:0]  gnt;
        logic [14:0] route;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_own[5];
    int   m_ptr[5];
    int   m_cred[5];
    bit   cnt_en   = 1'b0;
    int   grant_cnt = 0;
    logic [4:0]  last_pop;
    logic [14:0] last_route;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] dst(input int d0, input int d1, input int d2,
                                        input int d3, input int d4);
        return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    // Reference allocator: returns this cycle's outputs, then advances state.
    task automatic model_step(input logic r, input logic [4:0] v, input logic [14:0] d,
                              input logic [4:0] t, input logic [4:0] ret, output exp_t e);
        bit held[5];
        int w;
        int c;
        bit was_idle;
        e = '0;
        if (r) begin
            for (int o = 0; o < 5; o++) begin
                m_own[o] = -1; m_ptr[o] = 4; m_cred[o] = 4;
            end
            return;
        end
        for (int i = 0; i < 5; i++) held[i] = 1'b0;
        for (int o = 0; o < 5; o++) if (m_own[o] >= 0) held[m_own[o]] = 1'b1;
        for (int o = 0; o < 5; o++) begin
            w = -1;
            was_idle = (m_own[o] < 0);
            if (!was_idle) begin
                if (v[m_own[o]] && m_cred[o] > 0) w = m_own[o];
            end else begin
                for (int k = 1; k <= 5; k++) begin
                    c = (m_ptr[o] + k) % 5;
                    if (w < 0 && v[c] && int'(d[3*c +: 3]) == o && !held[c] &&
                        c != o && m_cred[o] > 0)
                        w = c;
                end
            end
            if (w >= 0) begin
                e.gnt[o] = 1'b1;
                e.route[3*o +: 3] = 3'(w);
                e.pop[w] = 1'b1;
                if (was_idle) begin
                    m_ptr[o] = w;
                    if (!t[w]) m_own[o] = w;
                end else if (t[w]) begin
                    m_own[o] = -1;
                end
            end
            if (w >= 0 && !ret[o]) m_cred[o]--;
            else if (w < 0 && ret[o] && m_cred[o] < 4) m_cred[o]++;
        end
    endtask

    // One cycle: drive, predict, compare at the falling edge, move past the rising edge.
    task automatic step(input logic r, input logic [4:0] v, input logic [14:0] d,
                        input logic [4:0] t, input logic [4:0] ret);
        exp_t e;
        rst = r; req_valid_i = v; req_dest_i = d; req_tail_i = t; credit_return_i = ret;
        model_step(r, v, d, t, ret, e);
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check_eq("pop", 32'(pop_o), 32'(e.pop));
        check_eq("grant", 32'(grant_access_o), 32'(e.gnt));
        check_eq("route", 32'(address_route_o), 32'(e.route));
        last_pop   = pop_o;
        last_route = address_route_o;
        if (cnt_en) grant_cnt += int'(grant_access_o[1]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int o = 0; o < 5; o++) begin
            m_own[o] = -1; m_ptr[o] = 4; m_cred[o] = 4;
        end
        rst = 1'b1; req_valid_i = '0; req_dest_i = '0; req_tail_i = '0; credit_return_i = '0;
        @(posedge clk);
        #1;

        // Reset, then W and L single-flit packets to E: W first, then L.
        step(1'b1, 5'b00000, 15'd0, 5'b00000, 5'b00000);
        step(1'b1, 5'b11000, dst(0, 0, 0, 2, 2), 5'b11000, 5'b00000);
        step(1'b0, 5'b11000, dst(0, 0, 0, 2, 2), 5'b11000, 5'b00000);
        check_eq("t1_route_E_is_W", 32'(last_route[8:6]), 32'd3);
        check_eq("t1_pop_W", 32'(last_pop), 32'b01000);
        step(1'b0, 5'b10000, dst(0, 0, 0, 0, 2), 5'b10000, 5'b00000);
        check_eq("t1_route_E_is_L", 32'(last_route[8:6]), 32'd4);
        step(1'b0, 5'b00000, 15'd0, 5'b00000, 5'b00000);

        // Fairness: N, S, L contend for W; returns keep credit topped up.
        for (int k = 0; k < 6; k++)
            step(1'b0, 5'b10011, dst(3, 3, 0, 0, 3), 5'b10011, 5'b01000);

        // Wormhole: 3-flit S packet to N holds N; E gets it after the tail.
        step(1'b0, 5'b00110, dst(0, 0, 0, 0, 0), 5'b00100, 5'b00000);
        step(1'b0, 5'b00110, dst(0, 0, 0, 0, 0), 5'b00100, 5'b00000);
        check_eq("t3_locked_S", 32'(last_route[2:0]), 32'd1);
        step(1'b0, 5'b00110, dst(0, 0, 0, 0, 0), 5'b00110, 5'b00000);
        step(1'b0, 5'b00100, dst(0, 0, 0, 0, 0), 5'b00100, 5'b00000);
        check_eq("t3_E_after_tail", 32'(last_route[2:0]), 32'd2);

        // Credits: L streams 6 flits to S, only 4 fit.
        step(1'b1, 5'b00000, 15'd0, 5'b00000, 5'b00000);
        cnt_en = 1'b1;
        for (int k = 0; k < 6; k++)
            step(1'b0, 5'b10000, dst(0, 0, 0, 0, 1), 5'b10000, 5'b00000);
        cnt_en = 1'b0;
        check_eq("t4_grants_with_4_credits", 32'(grant_cnt), 32'd4);
        step(1'b0, 5'b10000, dst(0, 0, 0, 0, 1), 5'b10000, 5'b00010);
        check_eq("t4_return_not_same_cycle", 32'(last_pop), 32'd0);
        step(1'b0, 5'b10000, dst(0, 0, 0, 0, 1), 5'b10000, 5'b00010);
        check_eq("t4_return_next_cycle", 32'(last_pop), 32'b10000);
        step(1'b0, 5'b10000, dst(0, 0, 0, 0, 1), 5'b10000, 5'b00000);
        step(1'b0, 5'b10000, dst(0, 0, 0, 0, 1), 5'b10000, 5'b00000);

        // Reset mid-packet: E holds W, reset, then N wins W fresh.
        step(1'b1, 5'b00000, 15'd0, 5'b00000, 5'b00000);
        step(1'b0, 5'b00100, dst(0, 0, 3, 0, 0), 5'b00000, 5'b00000);
        step(1'b0, 5'b00100, dst(0, 0, 3, 0, 0), 5'b00000, 5'b00000);
        step(1'b1, 5'b00101, dst(3, 0, 3, 0, 0), 5'b00001, 5'b00000);
        check_eq("t5_quiet_in_reset", 32'(last_pop), 32'd0);
        step(1'b0, 5'b00101, dst(3, 0, 3, 0, 0), 5'b00001, 5'b00000);
        check_eq("t5_N_wins_W", 32'(last_pop), 32'b00001);
        for (int k = 0; k < 4; k++)
            step(1'b0, 5'b00100, dst(0, 0, 3, 0, 0), 5'b00000, 5'b00000);

        // Illegal heads: N U-turn and W to port 6 are never granted.
        step(1'b1, 5'b00000, 15'd0, 5'b00000, 5'b00000);
        for (int k = 0; k < 3; k++)
            step(1'b0, 5'b01001, dst(0, 0, 0, 6, 0), 5'b01001, 5'b00000);
        check_eq("t6_illegal_no_pop", 32'(last_pop), 32'd0);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_switch_alloc.md
# noc_switch_alloc

Switch allocator for one NoC router: examines the head flit of the five input queues (N, S, E, W, L) and decides, per output port, which input drives the crossbar this cycle. It is the control side of the crossbar: it produces the per-output grant and input-select signals, plus the dequeue strobes back to the input queues. It enforces wormhole packet locking, round-robin fairness and credit-based flow control toward downstream buffers.

## Interface
Port index / encoding everywhere: 0=N, 1=S, 2=E, 3=W, 4=L; vector bit i refers to port i.
- CREDITS, 4, downstream buffer depth per output; credit counters are $clog2(CREDITS+1) bits wide
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  5  input queue i non-empty (head flit present)
- req_dest_i  in  15  3-bit output port requested by input i's head flit, at [3i+2:3i]; meaningful for head flits only
- req_tail_i  in  5  input i's head flit is a packet tail
- credit_return_i  in  5  downstream of output o freed one slot (1-cycle pulse)
- pop_o  out  5  dequeue input i at this clock edge
- grant_access_o  out  5  output o is driven this cycle; bit o feeds crossbar grant_access_{north..local}_i
- address_route_o  out  15  3-bit input index feeding output o, at [3o+2:3o]; feeds crossbar address_route_{n..l}_i

## Operation
- Outputs are combinational from the current inputs and registered state; all state updates at the rising clk edge.
- Per-output state: lock FSM {IDLE, LOCKED(owner)}, rr pointer ptr[o] (3b), credit counter cred[o].
- IDLE output o: candidates are inputs i with req_valid_i[i], req_dest_i[i]==o, i not locked to any output, i != o (no U-turn), and cred[o] > 0. Winner is the first candidate searching ptr[o]+1, ptr[o]+2, ... mod 5.
- On an IDLE grant to i: ptr[o] <= i. If req_tail_i[i]=0, go to LOCKED(i); a single-flit packet (tail on head) stays IDLE.
- LOCKED(i) output o: grant iff req_valid_i[i] and cred[o] > 0; req_dest_i[i] is ignored. A granted tail returns the output to IDLE. ptr[o] is unchanged while locked.
- Grant to i at o: grant_access_o[o]=1, address_route_o[o]=i, pop_o[i]=1. At most one grant per input per cycle (guaranteed, since an input targets one output).
- Credits: cred[o] decrements on grant and increments on credit_return_i[o]. Both in one cycle: unchanged. A return at cred==CREDITS saturates and is flagged by an assertion.
- req_dest values 5-7, or dest==own port: never granted; assertion fires.
- No grant: grant_access_o[o]=0, address_route_o[o]=0.

## Timing
- Zero-cycle decision: grant, select and pop all assert in the same cycle as the qualifying request. The crossbar passes the queue head that cycle, and the queue advances at the edge.
- Throughput: one flit per output per cycle while credits last.
- Reset (also mid-packet): all locks IDLE, cred[o]=CREDITS, ptr[o]=4 (first search starts at N). While rst=1, pop_o, grant_access_o and address_route_o are forced to 0.
- A credit returned in cycle t is usable in cycle t+1.

## Structure
- Package noc_pkg: port enum (PORT_N..PORT_L), NUM_PORTS=5, PORT_W=3, and the lock-state typedef.
- Sub-module rr_arbiter: 5-request round-robin arbiter with a pointer input, instantiated once per output. Lock and credit logic stay in noc_switch_alloc.

## Test plan
- Reset, then W and L single-flit heads both to dest E: cycle 1 grants W (address_route E=3, pop W). Cycle 2 grants L (route 4). cred[E] goes 4→3→2.
- Contention fairness: N, S and L continuously request W with single-flit packets. Grants rotate N, S, L, N, … and no input waits more than 2 cycles.
- Wormhole lock: S sends 3-flit packet to N while E requests N. All three S flits are granted consecutively and E is granted the cycle after the S tail.
- Credits: CREDITS=4, no returns, L streams 6 flits to S. Exactly 4 grants occur, then none. One credit_return_i[S] pulse gives exactly 1 more grant the next cycle. A simultaneous grant and return holds cred.
- Reset mid-packet: assert rst while E is LOCKED to output W. The cycle after reset, W arbitrates fresh (N wins if it requests W), and cred resets to 4.
- Illegal: N head with dest 0 (U-turn) and W head with dest 6 → never granted, pop_o stays 0, assertions fire.
